temperature_average: RTL and testbench
======================================

# temperature_average

Sequential averaging stage that consumes the active-sensor temperature sum and active-sensor count produced by the sensor input stage. It computes `floor(sum / count)` with an iterative 16-step restoring divider. It then classifies the 8-bit average against heating and cooling thresholds. Results are held until the next computation, and a one-cycle `valid_o` pulse feeds the downstream actuator/display logic.

## Interface

Parameters:

- `T_LOW`, default 19: heating threshold; `heat_o` is set when avg < `T_LOW`.
- `T_HIGH`, default 26: cooling threshold; `cool_o` is set when avg > `T_HIGH`. Requires `T_LOW` ≤ `T_HIGH`.

Ports:

- `clk_i` input 1: single clock, rising edge.
- `rst_n_i` input 1: reset, asynchronous, active-low.
- `start_i` input 1: request a computation; sampled only in IDLE.
- `temp_sum_i` input 16: sum of active sensor temperatures (unsigned).
- `nr_active_sensors_i` input 8: number of active sensors (unsigned).
- `busy_o` output 1: high whenever state ≠ IDLE.
- `valid_o` output 1: one-cycle pulse; the result outputs are updated in this cycle.
- `avg_o` output 8: average, floor, saturated to 255.
- `heat_o` output 1: avg below `T_LOW`.
- `cool_o` output 1: avg above `T_HIGH`.
- `no_sensor_o` output 1: last request had zero active sensors.

## Operation

- FSM states:
  - IDLE → DIVIDE on `start_i`=1 with count ≠ 0.
  - IDLE → DONE on `start_i`=1 with count = 0.
  - DIVIDE → DONE after the 16th iteration.
  - DONE → IDLE unconditionally.
- Operand latching: at the accepting edge, `temp_sum_i` loads the dividend register and `nr_active_sensors_i` loads the divisor register. Input changes after that edge are ignored until IDLE.
- Divider:
  - Restoring shift-subtract over a 9-bit partial remainder, a 16-bit quotient shift register and a 4-bit iteration counter (0..15).
  - Each iteration:
    - rem = {rem[7:0], dividend MSB}; shift the dividend left.
    - If rem ≥ divisor: rem −= divisor and shift in quotient bit 1; else shift in 0.
- DONE, count ≠ 0:
  - `avg_o` = (quotient > 255) ? 255 : quotient[7:0].
  - `heat_o` = (avg < `T_LOW`); `cool_o` = (avg > `T_HIGH`); both use the saturated avg.
  - `no_sensor_o` = 0.
- DONE, count = 0:
  - `avg_o` = 0, `heat_o` = 0, `cool_o` = 0, `no_sensor_o` = 1.
  - No division is performed.
- Outputs are registered and hold their values between `valid_o` pulses.
- `start_i` while `busy_o`=1 (including the DONE cycle) is ignored. It is not queued.
- `start_i` is level-sampled: if held high, a new computation starts on every IDLE edge.
- Reset (asynchronous, any state, including mid-division) sets:
  - state IDLE;
  - `busy_o`, `valid_o`, `avg_o`, `heat_o`, `cool_o`, `no_sensor_o` = 0;
  - counter and datapath registers = 0.
- No partial result is ever emitted after a reset.

## Timing

- Edge E0: `start_i` is sampled high in IDLE; `busy_o` rises after E0.
- Nonzero count:
  - Iterations occur at edges E1..E16; the state enters DONE at E16.
  - At E17 the outputs are loaded, `valid_o`=1 for exactly one cycle (E17→E18), and the state returns to IDLE.
  - `busy_o` is high from E0 to E17.
- Zero count:
  - DONE is entered at E0.
  - At E1 the outputs are loaded and `valid_o` pulses for one cycle.
  - `busy_o` is high for one cycle.
- Back-to-back throughput: the earliest next accepting edge is E18 (nonzero count) or E2 (zero count).
- Latency from the accepting edge to `valid_o`: 17 cycles (nonzero count), 1 cycle (zero count).

## Test plan

1. Basic average: sum=125, count=5, `start_i` pulse.
   - At E17: `avg_o`=25, `heat_o`=0, `cool_o`=0, `no_sensor_o`=0.
   - `valid_o` is high for exactly 1 cycle; `busy_o` is high for E0..E17.
2. Floor and heat: sum=94, count=5 → `avg_o`=18, `heat_o`=1.
   - Then sum=135, count=5 → `avg_o`=27, `cool_o`=1, `heat_o`=0.
3. Threshold boundaries:
   - sum=95, count=5 → avg 19, `heat_o`=0.
   - sum=130, count=5 → avg 26, `cool_o`=0.
4. Zero count and saturation:
   - sum=300, count=0 → at E1: `no_sensor_o`=1, `avg_o`=0, `valid_o` pulse.
   - Then sum=1000, count=1 → `avg_o`=255, `cool_o`=1.
5. Busy protection: start with sum=125, count=5.
   - Re-pulse `start_i` with sum=50, count=1 at E5, and change the inputs during DIVIDE.
   - Required: a single `valid_o` pulse with `avg_o`=25; no second result.
6. Reset mid-operation: assert `rst_n_i`=0 between E8 and E9.
   - All outputs go to 0 immediately (asynchronously); no `valid_o` pulse.
   - After release, a new start with sum=60, count=3 yields `avg_o`=20 at E17.

Source files
------------

// File: rtl/temperature_average.sv
// Averaging stage: floor(temp_sum / nr_active_sensors) via a 16-step restoring
// divider, saturated to 8 bits and classified against heat/cool thresholds.
module temperature_average #(
  parameter int unsigned T_LOW  = 19,
  parameter int unsigned T_HIGH = 26
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [15:0] temp_sum_i,
  input  logic [7:0]  nr_active_sensors_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [7:0]  avg_o,
  output logic        heat_o,
  output logic        cool_o,
  output logic        no_sensor_o
);

  localparam logic [7:0] T_LOW_B  = T_LOW[7:0];
  localparam logic [7:0] T_HIGH_B = T_HIGH[7:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [15:0] dividend;
  logic [15:0] quotient;
  logic [7:0]  divisor;
  logic [8:0]  rem;
  logic [3:0]  iter;

  logic [8:0]  rem_shift;
  logic [8:0]  rem_next;
  logic        q_bit;
  logic [7:0]  avg_sat;

  // Restoring step: remainder always stays below the divisor, so 9 bits suffice.
  always_comb begin
    rem_shift = (rem << 1) | {8'd0, dividend[15]};
    rem_next  = rem_shift;
    q_bit     = 1'b0;
    if (rem_shift >= {1'b0, divisor}) begin
      rem_next = rem_shift - {1'b0, divisor};
      q_bit    = 1'b1;
    end else begin
      rem_next = rem_shift;
      q_bit    = 1'b0;
    end
    avg_sat = (quotient > 16'd255) ? 8'd255 : quotient[7:0];
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a zero count skips the divider entirely.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          next_state = (nr_active_sensors_i == 8'd0) ? DONE : DIVIDE;
        end else begin
          next_state = IDLE;
        end
      end
      DIVIDE: begin
        if (iter == 4'd15) begin
          next_state = DONE;
        end else begin
          next_state = DIVIDE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Divider datapath: operands latched on the accepting edge only.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dividend <= 16'd0;
      divisor  <= 8'd0;
      rem      <= 9'd0;
      quotient <= 16'd0;
      iter     <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            dividend <= temp_sum_i;
            divisor  <= nr_active_sensors_i;
            rem      <= 9'd0;
            quotient <= 16'd0;
            iter     <= 4'd0;
          end
        end
        DIVIDE: begin
          dividend <= {dividend[14:0], 1'b0};
          rem      <= rem_next;
          quotient <= {quotient[14:0], q_bit};
          iter     <= iter + 4'd1;
        end
        default: begin
          iter <= 4'd0;
        end
      endcase
    end
  end

  // Result registers: loaded only in DONE, held otherwise.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o     <= 1'b0;
      avg_o       <= 8'd0;
      heat_o      <= 1'b0;
      cool_o      <= 1'b0;
      no_sensor_o <= 1'b0;
    end else if (state == DONE) begin
      valid_o <= 1'b1;
      if (divisor == 8'd0) begin
        avg_o       <= 8'd0;
        heat_o      <= 1'b0;
        cool_o      <= 1'b0;
        no_sensor_o <= 1'b1;
      end else begin
        avg_o       <= avg_sat;
        heat_o      <= (avg_sat < T_LOW_B);
        cool_o      <= (avg_sat > T_HIGH_B);
        no_sensor_o <= 1'b0;
      end
    end else begin
      valid_o <= 1'b0;
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_temperature_average.sv
// Randomized and directed self-checking bench for temperature_average against
// an arithmetic reference model (integer divide, saturate, threshold compare).
module tb_temperature_average;

  localparam int unsigned T_LOW  = 19;
  localparam int unsigned T_HIGH = 26;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] temp_sum;
  logic [7:0]  nr_active;
  logic        busy;
  logic        valid;
  logic [7:0]  avg;
  logic        heat;
  logic        cool;
  logic        no_sensor;

  int n_checks;
  int n_pass;

  temperature_average #(.T_LOW(T_LOW), .T_HIGH(T_HIGH)) dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .start_i             (start),
    .temp_sum_i          (temp_sum),
    .nr_active_sensors_i (nr_active),
    .busy_o              (busy),
    .valid_o             (valid),
    .avg_o               (avg),
    .heat_o              (heat),
    .cool_o              (cool),
    .no_sensor_o         (no_sensor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the stated rules.
  task automatic model(input int unsigned s, input int unsigned c,
                       output int unsigned e_avg, output int unsigned e_heat,
                       output int unsigned e_cool, output int unsigned e_nos);
    int unsigned q;
    if (c == 0) begin
      e_avg = 0; e_heat = 0; e_cool = 0; e_nos = 1;
    end else begin
      q      = s / c;
      e_avg  = (q > 255) ? 255 : q;
      e_heat = (e_avg < T_LOW) ? 1 : 0;
      e_cool = (e_avg > T_HIGH) ? 1 : 0;
      e_nos  = 0;
    end
  endtask

  task automatic check_result(input string tag, input int unsigned s, input int unsigned c);
    int unsigned e_avg, e_heat, e_cool, e_nos;
    model(s, c, e_avg, e_heat, e_cool, e_nos);
    check_eq({tag, "_avg"}, 32'(avg), e_avg);
    check_eq({tag, "_heat"}, 32'(heat), e_heat);
    check_eq({tag, "_cool"}, 32'(cool), e_cool);
    check_eq({tag, "_nosensor"}, 32'(no_sensor), e_nos);
  endtask

  // One full transaction: accept at E0, scramble inputs, wait for valid (bounded).
  task automatic run(input string tag, input logic [15:0] s, input logic [7:0] c);
    int lat;
    int exp_lat;
    @(negedge clk);
    start = 1'b1; temp_sum = s; nr_active = c;
    @(posedge clk); #1;
    check_eq({tag, "_busy_e0"}, 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    temp_sum = 16'($urandom);
    nr_active = 8'($urandom);
    exp_lat = (c == 8'd0) ? 1 : 17;
    lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (valid) lat = i;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_result(tag, 32'(s), 32'(c));
    check_eq({tag, "_busy_at_valid"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_valid_1cyc"}, 32'(valid), 32'd0);
  endtask

  initial begin
    int nv;
    int lat;
    logic [15:0] rs;
    logic [7:0]  rc;
    n_checks = 0;
    n_pass = 0;
    rst_n = 1'b0; start = 1'b0; temp_sum = 16'd0; nr_active = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_avg", 32'(avg), 32'd0);
    check_eq("rst_flags", 32'({heat, cool, no_sensor}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("basic", 16'd125, 8'd5);
    run("heat", 16'd94, 8'd5);
    run("cool", 16'd135, 8'd5);
    run("tlow_edge", 16'd95, 8'd5);
    run("thigh_edge", 16'd130, 8'd5);
    run("zero_cnt", 16'd300, 8'd0);
    run("saturate", 16'd1000, 8'd1);
    run("max_sum", 16'hFFFF, 8'd255);

    // Level-sampled start with zero count: a result every other cycle.
    @(negedge clk);
    start = 1'b1; temp_sum = 16'd50; nr_active = 8'd0;
    @(posedge clk);
    nv = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (valid) nv++;
    end
    check_eq("level_start_pulses", 32'(nv), 32'd10);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);

    // Busy protection: restart at E5 and input changes during DIVIDE are ignored.
    @(negedge clk);
    start = 1'b1; temp_sum = 16'd125; nr_active = 8'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; temp_sum = 16'd999; nr_active = 8'd7;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; temp_sum = 16'd50; nr_active = 8'd1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; temp_sum = 16'd3; nr_active = 8'd0;
    lat = 0;
    for (int i = 6; i <= 40 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (valid) lat = i;
    end
    check_eq("busyprot_latency", 32'(lat), 32'd17);
    check_result("busyprot", 32'd125, 32'd5);
    nv = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (valid) nv++;
    end
    check_eq("busyprot_no_second", 32'(nv), 32'd0);

    // Asynchronous reset between E8 and E9.
    @(negedge clk);
    start = 1'b1; temp_sum = 16'd125; nr_active = 8'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_valid", 32'(valid), 32'd0);
    check_eq("midrst_avg", 32'(avg), 32'd0);
    check_eq("midrst_flags", 32'({heat, cool, no_sensor}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (valid) nv++;
    end
    check_eq("midrst_no_valid", 32'(nv), 32'd0);
    run("after_rst", 16'd60, 8'd3);

    // Random transactions, biased toward small counts and zero.
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 3))
        0:       rc = 8'd0;
        1:       rc = 8'($urandom_range(1, 4));
        default: rc = 8'($urandom_range(1, 255));
      endcase
      rs = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 400)) : 16'($urandom);
      run("rand", rs, rc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
